wptr_full: RTL
==============

// Module: wptr_full
// PURPOSE
//   Write-side pointer and full-flag controller for the FIFO memory (fifomem).
//   Drives fifomem waddr/wclken/wfull in the write clock domain and keeps the binary and Gray write pointers.
//   Compares against the read pointer (Gray, already 2-flop synchronized into wclk) to produce full,
//   almost-full, occupancy and a sticky overflow error. Exported wptr (Gray) feeds the read-side synchronizer.
// PARAMETERS
//   addr         4   memory address bits; DEPTH = 1<<addr; legal addr >= 2
//   AFULL_THRESH 12  walmost_full asserts when occupancy >= this value (1..DEPTH)
// PORTS
//   wclk          in   1       write clock; all state updates on rising edge
//   wrst          in   1       asynchronous, active-high reset
//   winc          in   1       write request from producer (data presented to fifomem wdata same cycle)
//   wq2_rptr      in   addr+1  read pointer, Gray, already synchronized into wclk
//   waddr         out  addr    memory write address = wbin[addr-1:0]
//   wclken        out  1       memory write enable = winc & ~wfull (combinational)
//   wptr          out  addr+1  write pointer, Gray, registered
//   wfull         out  1       FIFO full, registered
//   walmost_full  out  1       occupancy >= AFULL_THRESH, registered
//   wcount        out  addr+1  occupancy seen from write side, 0..DEPTH, registered
//   woverflow     out  1       sticky: write attempted while full
// BEHAVIOUR
//   Reset (async assert, sync release at wclk): wbin=0, wptr=0, wfull=0, walmost_full=0,
//     wcount=0, woverflow=0; hence waddr=0, wclken=winc. Reset mid-operation drops all state immediately.
//   Accept: push = winc & ~wfull. wbinnext = wbin + push (mod 2^(addr+1), natural wrap, no saturation).
//   wgraynext = (wbinnext >> 1) ^ wbinnext. wbin <= wbinnext; wptr <= wgraynext every cycle.
//   Full: wfull <= (wgraynext == {~wq2_rptr[addr:addr-1], wq2_rptr[addr-2:0]}).
//     Full goes high on the edge that stores the DEPTH-th entry (zero latency after that write).
//     Full deasserts only one cycle after wq2_rptr changes (pessimistic; never false-empty/overrun).
//   Occupancy: rbin_s = Gray-to-binary(wq2_rptr); wcount <= (wbinnext - rbin_s) mod 2^(addr+1).
//     Value range 0..DEPTH; DEPTH encoded as 1<<addr. wcount==DEPTH iff wfull next cycle.
//   walmost_full <= ((wbinnext - rbin_s) mod 2^(addr+1)) >= AFULL_THRESH.
//   woverflow <= woverflow | (winc & wfull); cleared only by wrst. Write while full: pointers hold,
//     wclken=0, memory untouched.
//   Simultaneous push and wq2_rptr advance in same cycle: both applied to next-state compare;
//     at full with rptr advancing, push is still blocked this cycle (wfull registered).
//   Wrap: pointer MSB toggles each DEPTH writes; Gray sequence changes exactly one bit per push.
//   wptr/wq2_rptr Gray only; no combinational path from wq2_rptr to any output.
//   Latency: write accepted same cycle as winc; status outputs valid one edge after cause.
// TESTING
//   1. Reset, wq2_rptr=0, winc=1 for 16 cycles -> waddr 0..15, wclken=1 each; after 16th edge
//      wfull=1, wcount=16, wptr=5'b11000, woverflow=0.
//   2. From full, winc=1 two more cycles -> wclken=0, waddr stays 0, wptr unchanged, woverflow=1 and stays.
//   3. From full, set wq2_rptr=5'b00001 (rbin 1) -> next edge wfull=0, wcount=15; write -> full again, wptr=5'b11001.
//   4. Threshold: rptr=0, 11 writes -> walmost_full=0, wcount=11; 12th write -> walmost_full=1.
//   5. Wrap: loop 40 writes with rptr tracking wptr after 2-cycle delay -> wfull never set,
//      wptr Hamming distance 1 per push, waddr wraps 15->0, MSB toggles at writes 16 and 32.
//   6. Assert wrst mid-burst (wcount=7, woverflow=1) -> all outputs 0 immediately, no clock needed;
//      after release first write uses waddr=0.

Source files
------------

// File: rtl/wptr_full_if.sv
// Write-side bundle between the FIFO producer and the write pointer/full controller.
// The master drives the write request and the synchronized read pointer; the slave returns pointer and status.
interface wptr_full_if #(
  parameter int addr = 4
);
  logic            winc;
  logic [addr:0]   wq2_rptr;
  logic [addr-1:0] waddr;
  logic            wclken;
  logic [addr:0]   wptr;
  logic            wfull;
  logic            walmost_full;
  logic [addr:0]   wcount;
  logic            woverflow;

  modport master (
    output winc,
    output wq2_rptr,
    input  waddr,
    input  wclken,
    input  wptr,
    input  wfull,
    input  walmost_full,
    input  wcount,
    input  woverflow
  );

  modport slave (
    input  winc,
    input  wq2_rptr,
    output waddr,
    output wclken,
    output wptr,
    output wfull,
    output walmost_full,
    output wcount,
    output woverflow
  );
endinterface

// File: rtl/wptr_full.sv
// Write-side pointer and full-flag controller of an asynchronous FIFO.
// Keeps binary and Gray write pointers and derives full, almost-full, occupancy and a sticky overflow.
module wptr_full #(
  parameter int addr         = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic       wclk,
  input  logic       wrst,
  wptr_full_if.slave bus
);
  localparam logic [addr:0] AFULL_LEVEL = (addr + 1)'(AFULL_THRESH);

  logic [addr:0] wbin;
  logic [addr:0] wgray;
  logic          full_q;
  logic          afull_q;
  logic [addr:0] count_q;
  logic          ovf_q;

  logic          push;
  logic [addr:0] wbin_next;
  logic [addr:0] wgray_next;
  logic [addr:0] rbin_s;
  logic [addr:0] occ_next;
  logic [addr:0] full_target;

  function automatic logic [addr:0] gray_to_bin(input logic [addr:0] g);
    logic [addr:0] b;
    b = g;
    for (int i = addr - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign push       = bus.winc & ~full_q;
  assign wbin_next  = wbin + {{addr{1'b0}}, push};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  assign rbin_s     = gray_to_bin(bus.wq2_rptr);
  assign occ_next   = wbin_next - rbin_s;

  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted, rest equal.
  assign full_target = {~bus.wq2_rptr[addr:addr-1], bus.wq2_rptr[addr-2:0]};

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin    <= '0;
      wgray   <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin    <= wbin_next;
      wgray   <= wgray_next;
      full_q  <= (wgray_next == full_target);
      afull_q <= (occ_next >= AFULL_LEVEL);
      count_q <= occ_next;
      ovf_q   <= ovf_q | (bus.winc & full_q);
    end
  end

  assign bus.waddr        = wbin[addr-1:0];
  assign bus.wclken       = push;
  assign bus.wptr         = wgray;
  assign bus.wfull        = full_q;
  assign bus.walmost_full = afull_q;
  assign bus.wcount       = count_q;
  assign bus.woverflow    = ovf_q;
endmodule
